// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice fed LSB-first from shift registers,
// with a carry flip-flop, a bit counter and a start/busy/done handshake.

module fa_ha (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cf;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s_bit;
  logic             w_c_bit;
  logic             w_accept;
  logic             w_last;

  fa_ha u_fa (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .i_c (r_cf),
    .o_s (w_s_bit),
    .o_c (w_c_bit)
  );

  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The unused encoding falls through to IDLE via the default.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_cf    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_cf  <= i_c;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= {w_s_bit, r_acc[WIDTH-1:1]};
      r_cf  <= w_c_bit;
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_cnt <= r_cnt + CW'(1);
      // Results update only on the final bit so sum/carry hold through the next RUN.
      if (w_last) begin
        r_sum   <= {w_s_bit, r_acc[WIDTH-1:1]};
        r_carry <= w_c_bit;
      end
    end
  end

  assign o_busy  = (r_state == S_RUN);
  assign o_done  = (r_state == S_DONE);
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against an arithmetic model.

module tb_serial_adder;
  logic        clk;
  logic        rst;
  logic        s8, c8, busy8, done8, carry8;
  logic [7:0]  a8, b8, sum8;
  logic        s16, c16, busy16, done16, carry16;
  logic [15:0] a16, b16, sum16;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_a(a8), .i_b(b8), .i_c(c8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(carry8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(s16), .i_a(a16), .i_b(b16), .i_c(c16),
    .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(carry16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the negedge right after the accepting edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; c8 = c;
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    s16 = 1'b1; a16 = a; b16 = b; c16 = c;
    @(negedge clk);
    s16 = 1'b0;
  endtask

  // lat = negedges from now until done is seen; busy_cnt = busy cycles seen on the way.
  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy8, done8, sum8, carry8, busy16, done16, sum16, carry16} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got b=%b d=%b s=%h c=%b expected all zero", busy8, done8, sum8, carry8);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy8, done8, sum8, carry8, busy16, done16, sum16, carry16} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got b=%b d=%b s=%h c=%b expected all zero",
                 i, busy8, done8, sum8, carry8);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    launch8(8'h35, 8'h4A, 1'b0);
    wait_done8(lat, bc);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    checks++;
    if ({carry8, sum8} !== 9'h07F) begin
      errors++; $display("FAIL basic_sum: got %b_%h expected 0_7f", carry8, sum8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done8, busy8);
    end
  endtask

  task automatic test_carry_ripple();
    int lat, bc;
    launch8(8'hFF, 8'h00, 1'b1);
    wait_done8(lat, bc);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL ripple_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({carry8, sum8} !== 9'h100) begin
      errors++; $display("FAIL ripple_ff_00_1: got %b_%h expected 1_00", carry8, sum8);
    end
    launch8(8'hFF, 8'hFF, 1'b1);
    wait_done8(lat, bc);
    checks++;
    if ({carry8, sum8} !== 9'h1FF) begin
      errors++; $display("FAIL ripple_ff_ff_1: got %b_%h expected 1_ff", carry8, sum8);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    launch8(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    @(negedge clk);
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8(lat, bc);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL ignore_latency: got %0d expected 5", lat);
    end
    checks++;
    if ({carry8, sum8} !== 9'h047) begin
      errors++; $display("FAIL ignore_sum: got %b_%h expected 0_47", carry8, sum8);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch8(8'hA0, 8'h0F, 1'b0);
    wait_done8(lat, bc);
    checks++;
    if ({carry8, sum8} !== 9'h0AF) begin
      errors++; $display("FAIL b2b_first: got %b_%h expected 0_af", carry8, sum8);
    end
    s8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || sum8 !== 8'hAF) begin
      errors++; $display("FAIL b2b_rerun: got busy=%b sum=%h expected 1 af", busy8, sum8);
    end
    wait_done8(lat, bc);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({carry8, sum8} !== 9'h002) begin
      errors++; $display("FAIL b2b_second: got %b_%h expected 0_02", carry8, sum8);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    launch8(8'h77, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, carry8} !== 11'h0) begin
      errors++;
      $display("FAIL midrun_reset: got b=%b d=%b s=%h c=%b expected all zero", busy8, done8, sum8, carry8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL midrun_idle: got busy=%b done=%b expected 0 0", busy8, done8);
    end
    launch8(8'h10, 8'h20, 1'b0);
    wait_done8(lat, bc);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL midrun_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({carry8, sum8} !== 9'h030) begin
      errors++; $display("FAIL midrun_sum: got %b_%h expected 0_30", carry8, sum8);
    end
  endtask

  task automatic test_random8();
    int lat, bc;
    logic [31:0] r;
    logic [7:0]  a, b;
    logic        c;
    logic [8:0]  exp;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom; a = r[7:0]; b = r[15:8]; c = r[16];
      exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
      launch8(a, b, c);
      wait_done8(lat, bc);
      checks++;
      if ({carry8, sum8} !== exp || lat !== 8) begin
        errors++;
        $display("FAIL rand8 #%0d %h+%h+%b: got %b_%h lat %0d expected %b_%h lat 8",
                 i, a, b, c, carry8, sum8, lat, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_random16();
    int lat;
    logic [31:0] r;
    logic [15:0] a, b;
    logic        c;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom; a = r[15:0]; b = r[31:16];
      r = $urandom; c = r[0];
      exp = {1'b0, a} + {1'b0, b} + {16'b0, c};
      launch16(a, b, c);
      wait_done16(lat);
      checks++;
      if ({carry16, sum16} !== exp || lat !== 16) begin
        errors++;
        $display("FAIL rand16 #%0d %h+%h+%b: got %b_%h lat %0d expected %b_%h lat 16",
                 i, a, b, c, carry16, sum16, lat, exp[16], exp[15:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    s8 = 1'b0;  a8 = '0;  b8 = '0;  c8 = 1'b0;
    s16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits directly downstream of the team's single-bit full adder (fa_ha): it feeds one bit pair plus the stored carry into one fa_ha instance per clock and assembles the returned sum bits into a parallel result. It trades a WIDTH-bit ripple chain for one full-adder slice, a carry flip-flop, shift registers, a bit counter and a start/done handshake. Used where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured on the edge that accepts start.
- b  input  WIDTH  operand B; captured on the edge that accepts start.
- c  input  1  carry-in; captured on the edge that accepts start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  registered result, (a+b+c) mod 2^WIDTH.
- carry  output  1  registered carry-out of the MSB.

## Operation
- States: IDLE, RUN, DONE. State is encoded in 2 bits; the unused encoding returns to IDLE on the next edge.
- Internal registers:
  - sa and sb: WIDTH-bit shift registers.
  - cf: carry flip-flop.
  - acc: WIDTH-bit sum shift register.
  - cnt: bit counter, $clog2(WIDTH)+1 bits.
  - sum_r and carry_r: result registers driving sum and carry.
- Bit-slice: exactly one fa_ha instance. Its inputs are sa[0], sb[0] and cf. Its outputs are s_bit and c_bit.
- Start acceptance: start is accepted in IDLE or DONE. On acceptance:
  - sa←a, sb←b, cf←c, cnt←0.
  - Next state is RUN.
- Start is ignored in RUN. There is no queueing and no abort.
- Each RUN edge:
  - acc←{s_bit, acc[WIDTH-1:1]}.
  - cf←c_bit.
  - sa and sb shift right by 1, zero-filled.
  - cnt←cnt+1.
- RUN ends on the edge where cnt==WIDTH-1. On that edge:
  - sum_r←{s_bit, acc[WIDTH-1:1]}.
  - carry_r←c_bit.
  - Next state is DONE.
- DONE lasts one cycle. If start is high, the next state is RUN (back-to-back operation). Otherwise the next state is IDLE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - sum and carry hold the last result unchanged through IDLE and through a following RUN. They change only on the edge that enters DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state←IDLE.
  - sa, sb, acc, cf, cnt, sum_r and carry_r all ←0.
  - Outputs: busy=0, done=0, sum=0, carry=0.
  - The partial operation is discarded. After rst falls, the first accepted start begins a fresh operation.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH each process one bit, LSB first.
- EWIDTH enters DONE. done is high in the cycle between EWIDTH and EWIDTH+1.
- Latency from the accepting edge to done high: WIDTH edges.
- Throughput with start held high: one result per WIDTH+1 cycles.
- busy is high from E0 to EWIDTH, i.e. exactly WIDTH cycles.
- a, b and c may change freely after E0. They are not sampled again until the next acceptance.
- rst asserted asynchronously clears the outputs immediately, without waiting for a clock edge.
- If rst is released on the same edge that start is high, start is not accepted on that edge. The first accepting edge is the next one.

## Test plan
- Reset/idle:
  - Assert rst mid-cycle → busy=0, done=0, sum=0, carry=0 immediately.
  - Release rst with start=0 for 5 cycles → all outputs stay 0.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, c=0, one-cycle start → busy high for 8 cycles, then done pulses for 1 cycle with sum=8'h7F, carry=0.
- Full carry ripple: a=8'hFF, b=8'h00, c=1 → sum=8'h00, carry=1, done exactly 8 edges after the accepting edge. Also a=8'hFF, b=8'hFF, c=1 → sum=8'hFF, carry=1.
- Busy protection and back-to-back:
  - Pulse start again in cycle 3 of RUN with different operands → ignored; the first result is still correct.
  - Hold start high during DONE with a=8'h01, b=8'h01 → RUN re-enters with no IDLE cycle; next done gives sum=8'h02, carry=0.
  - sum holds the previous result until the second done.
- Reset mid-operation: assert rst at cycle 4 of RUN → outputs clear. A new start with a=8'h10, b=8'h20, c=0 → sum=8'h30, carry=0, with correct 8-cycle latency.
- Randomized check: 1000 random a, b and c at WIDTH=8 and at WIDTH=16 → each {carry, sum} equals a+b+c from a reference model.
